burst_external_device: RTL
==========================

Name: burst_external_device

Overview:
Clocked, synthesizable successor to the behavioural external device model used by the DMA test system. It holds DEPTH beats of BEAT_WORDS×WORD_SIZE data, regenerated per transfer from an internal LFSR, and fires an interrupt after a programmable delay. The interrupt holds until the CPU acknowledges or a timeout expires. After acknowledge, the DMA controller reads beats by offset with a registered 1-cycle read. Sits beside the DMA controller/memory in the top-level testbench.

Parameters:
WORD_SIZE, 16, bits per word
BEAT_WORDS, 4, words per beat; data bus = BEAT_WORDS*WORD_SIZE
DEPTH, 3, beats per transfer (≥1)
OFFSET_W, 2, offset width; 2**OFFSET_W ≥ DEPTH
FIRE_CYCLES, 200, cycles from ARM entry to interrupt assertion (≥1)
IRQ_TIMEOUT, 50, cycles interrupt waits for ack before retry (0 = wait forever)
NUM_BURSTS, 2, transfers before DONE (0 = unlimited)
LFSR_SEED, 32'hACE1_2468, nonzero LFSR reset value

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
int_ack  in  1  CPU interrupt acknowledge, single-cycle pulse
rd_en  in  1  DMA read strobe
offset  in  OFFSET_W  beat index for read
interrupt  out  1  transfer request
data  out  BEAT_WORDS*WORD_SIZE  read data
data_valid  out  1  data holds a valid beat this cycle
rd_err  out  1  one-cycle pulse on illegal read
busy  out  1  high in FILL/IRQ/XFER
burst_cnt  out  8  completed transfers (saturates at 255)
miss_cnt  out  8  interrupt timeouts (saturates at 255)

Behaviour:
- Reset (async assert, sync release): state=FILL, all outputs 0, storage 0, LFSR=LFSR_SEED, counters 0.
- LFSR: 32-bit Galois, taps 32,22,2,1; advances once per FILL cycle only. Each word = low WORD_SIZE bits of LFSR.
- FILL: writes one word per cycle, beat 0 word 0 first, word index ascending within beat. Takes DEPTH*BEAT_WORDS cycles, then ARM.
- ARM: timer loads FIRE_CYCLES-1 on entry and decrements. At 0, moves to IRQ. interrupt rises the cycle IRQ is entered (registered).
- IRQ: interrupt=1.
  - int_ack → XFER; interrupt=0 next cycle.
  - Timeout counter reaching IRQ_TIMEOUT → interrupt=0, miss_cnt++, back to ARM. Storage is kept and the delay is re-armed.
  - ack in the same cycle as timeout: ack wins, no miss counted.
- XFER:
  - rd_en with offset<DEPTH → data<=storage[offset], data_valid=1 next cycle, beat counter++.
  - rd_en with offset≥DEPTH → data<=0, data_valid=0, rd_err pulse. Beat counter unchanged.
  - Repeated offsets are legal and counted.
  - No rd_en → data_valid=0 next cycle, data holds its last value.
  - When the beat counter reaches DEPTH (on the accepting edge): burst_cnt++. Go to DONE if burst_cnt+1==NUM_BURSTS (NUM_BURSTS≠0), else to FILL. The final read's data_valid still appears on the following cycle.
- rd_en outside XFER → rd_err pulse, data/data_valid unaffected (data_valid=0).
- int_ack outside IRQ is ignored.
- DONE: terminal, interrupt=0, busy=0. Only reset exits.
- Reset mid-operation (any state): immediate return to reset values. Transfer abandoned, LFSR reseeded.
- busy=1 in FILL, IRQ, XFER; 0 in ARM, DONE.

Decomposition:
- Shared package: state encoding (FILL, ARM, IRQ, XFER, DONE), LFSR tap constant, default WORD_SIZE/BEAT_WORDS.
- Sub-module: lfsr32 (clk, reset_n, en, seed param, q[31:0]), reusable by other stimulus devices.
- FSM, timers and storage stay in the top module.

Test Plan:
- Reset, then idle: after 12 fill + 200 arm cycles interrupt=1 at cycle 213 (±1 for reset release). storage[0] word0 = low 16 bits of LFSR after 0 steps (16'h2468).
- Ack at IRQ cycle 3, then rd_en offsets 0,1,2 back-to-back → data_valid high 3 consecutive cycles with matching beats. burst_cnt=1, FILL re-entered, second interrupt fires.
- No ack: interrupt drops after 50 cycles, miss_cnt=1. Re-fires 200 cycles later with identical storage contents.
- int_ack on the exact timeout cycle → XFER entered, miss_cnt stays 0.
- In XFER, rd_en offset=3 → rd_err=1 one cycle, data_valid=0, beat counter unchanged. rd_en during ARM → rd_err only.
- reset_n low mid-XFER after 1 beat → outputs 0 asynchronously. After release, the full sequence repeats with the same data. After 2 full bursts: DONE, busy=0, and no further interrupt for 1000 cycles.

Source files
------------

// File: rtl/burst_external_device_pkg.sv
// Shared definitions for the burst external device: FSM encoding, LFSR
// polynomial and default beat geometry.
`timescale 1ns/1ps
package burst_external_device_pkg;

  typedef enum logic [2:0] {
    FILL = 3'd0,
    ARM  = 3'd1,
    IRQ  = 3'd2,
    XFER = 3'd3,
    DONE = 3'd4
  } state_t;

  // Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int DEF_WORD_SIZE  = 16;
  localparam int DEF_BEAT_WORDS = 4;

  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/burst_external_device_lfsr32.sv
// 32-bit Galois LFSR that advances only when enabled; reusable by any
// stimulus device that needs a reproducible pseudo-random stream.
`timescale 1ns/1ps
module lfsr32
  import burst_external_device_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/burst_external_device.sv
// Clocked external device: fills beats from an LFSR, raises an interrupt after
// a programmable delay, then serves beat reads to the DMA controller.
`timescale 1ns/1ps
module burst_external_device
  import burst_external_device_pkg::*;
#(
  parameter int          WORD_SIZE   = DEF_WORD_SIZE,
  parameter int          BEAT_WORDS  = DEF_BEAT_WORDS,
  parameter int          DEPTH       = 3,
  parameter int          OFFSET_W    = 2,
  parameter int          FIRE_CYCLES = 200,
  parameter int          IRQ_TIMEOUT = 50,
  parameter int          NUM_BURSTS  = 2,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            int_ack,
  input  logic                            rd_en,
  input  logic [OFFSET_W-1:0]             offset,
  output logic                            interrupt,
  output logic [BEAT_WORDS*WORD_SIZE-1:0] data,
  output logic                            data_valid,
  output logic                            rd_err,
  output logic                            busy,
  output logic [7:0]                      burst_cnt,
  output logic [7:0]                      miss_cnt
);

  localparam int DATA_W = BEAT_WORDS * WORD_SIZE;
  localparam int NWORDS = DEPTH * BEAT_WORDS;
  localparam int FILL_W = $clog2(NWORDS + 1);
  localparam int BEAT_W = $clog2(DEPTH + 1);

  localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(NWORDS - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(DEPTH - 1);
  localparam logic [31:0]       FIRE_LOAD  = 32'(FIRE_CYCLES - 1);
  localparam logic [31:0]       TMO_LAST   = 32'(IRQ_TIMEOUT - 1);
  localparam logic [7:0]        BURST_LAST = 8'(NUM_BURSTS - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s == FILL) || (s == IRQ) || (s == XFER);
  endfunction

  state_t                state, state_nx;
  logic [FILL_W-1:0]     fill_idx;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [31:0]           timer;
  logic [31:0]           irq_cnt;
  logic [31:0]           lfsr_q;
  logic [WORD_SIZE-1:0]  lfsr_word;
  logic [WORD_SIZE-1:0]  mem [NWORDS];
  logic [DATA_W-1:0]     rd_beat;
  logic [DATA_W-1:0]     data_p1;
  logic                  vld_p1;
  logic                  offset_ok, rd_ok, rd_bad, irq_tmo, last_burst;

  lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == FILL),
    .q       (lfsr_q)
  );

  assign lfsr_word  = WORD_SIZE'(lfsr_q);
  assign offset_ok  = (32'(offset) < 32'(DEPTH));
  assign rd_ok      = rd_en && (state == XFER) && offset_ok;
  assign rd_bad     = rd_en && !((state == XFER) && offset_ok);
  assign irq_tmo    = (IRQ_TIMEOUT != 0) && (irq_cnt == TMO_LAST);
  assign last_burst = (NUM_BURSTS != 0) && (NUM_BURSTS <= 256) && (burst_cnt == BURST_LAST);

  // Word 0 of a beat sits in the least significant bits of the data bus
  always_comb begin
    rd_beat = '0;
    for (int b = 0; b < DEPTH; b++) begin
      if (offset == OFFSET_W'(b)) begin
        for (int w = 0; w < BEAT_WORDS; w++) begin
          rd_beat[w*WORD_SIZE +: WORD_SIZE] = mem[b*BEAT_WORDS + w];
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (fill_idx == FILL_LAST) state_nx = ARM;
      ARM:     if (timer == '0) state_nx = IRQ;
      IRQ: begin
        if (int_ack)      state_nx = XFER;
        else if (irq_tmo) state_nx = ARM;
      end
      XFER: begin
        if (rd_ok && (beat_cnt == BEAT_LAST)) state_nx = last_burst ? DONE : FILL;
      end
      DONE:    state_nx = DONE;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FILL;
      fill_idx  <= '0;
      beat_cnt  <= '0;
      timer     <= '0;
      irq_cnt   <= '0;
      interrupt <= 1'b0;
      busy      <= 1'b0;
      rd_err    <= 1'b0;
      burst_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      state     <= state_nx;
      interrupt <= (state_nx == IRQ);
      busy      <= is_busy(state_nx);
      rd_err    <= rd_bad;

      if (state == FILL) fill_idx <= (fill_idx == FILL_LAST) ? '0 : fill_idx + 1'b1;

      // Delay reloads on every ARM entry, including re-arm after a missed ack
      if ((state != ARM) && (state_nx == ARM)) timer <= FIRE_LOAD;
      else if ((state == ARM) && (timer != '0)) timer <= timer - 1'b1;

      irq_cnt <= (state == IRQ) ? irq_cnt + 1'b1 : '0;

      if ((state == IRQ) && !int_ack && irq_tmo) miss_cnt <= sat_inc(miss_cnt);

      if (rd_ok) begin
        beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
        if (beat_cnt == BEAT_LAST) burst_cnt <= sat_inc(burst_cnt);
      end
    end
  end

  // Storage and read stage; both are cleared by reset so no stale beat survives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
    end else if (state == FILL) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (fill_idx == FILL_W'(i)) mem[i] <= lfsr_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_ok;
      if (rd_ok)                          data_p1 <= rd_beat;
      else if (rd_en && (state == XFER))  data_p1 <= '0;
    end
  end

  assign data       = data_p1;
  assign data_valid = vld_p1;

endmodule
